// File: rtl/imm_encode.sv
// imm_encode: inverse of the datapath immediate extractor.
// Packs a signed immediate into an instruction template for the
// I/S/B/J/U formats, or expands a load-immediate request into one addi
// or a lui/addi pair. One request per cycle on a valid/ready input and
// a registered valid/ready output stage.
module imm_encode (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  immsrc,
    input  logic [31:0] base,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic        out_last
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_LUI   = 2'd2;

    localparam logic [2:0] F_I  = 3'b000;
    localparam logic [2:0] F_S  = 3'b001;
    localparam logic [2:0] F_B  = 3'b010;
    localparam logic [2:0] F_J  = 3'b011;
    localparam logic [2:0] F_U  = 3'b100;
    localparam logic [2:0] F_LI = 3'b101;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    // Encoder result: first word to present, its error flag, whether a
    // second (addi) word follows, and that second word.
    typedef struct packed {
        logic [31:0] word;
        logic        err;
        logic        two;
        logic [31:0] tail;
    } enc_t;

    logic [1:0]  state;
    logic [31:0] held;
    enc_t        enc;
    logic        accept;

    // Representability: upper bits must be a pure sign extension.
    logic        fits12, fits13, fits21;
    logic [4:0]  rd;
    logic [19:0] hi20;

    assign fits12 = (imm[31:11] == {21{imm[11]}});
    assign fits13 = (imm[31:12] == {20{imm[12]}});
    assign fits21 = (imm[31:20] == {12{imm[20]}});
    assign rd     = base[11:7];
    // Upper part rounded so the sign-extended low 12 bits of the addi
    // bring the sum back to imm; equals (imm + 0x800) >> 12.
    assign hi20   = imm[31:12] + {19'd0, imm[11]};

    // Combinational encoding of the incoming request.
    always_comb begin
        enc      = '0;
        enc.word = base;
        unique case (immsrc)
            F_I: begin
                enc.word = {imm[11:0], base[19:0]};
                enc.err  = !fits12;
            end
            F_S: begin
                enc.word = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
                enc.err  = !fits12;
            end
            F_B: begin
                enc.word = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
                enc.err  = !fits13 || imm[0];
            end
            F_J: begin
                enc.word = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
                enc.err  = !fits21 || imm[0];
            end
            F_U: begin
                enc.word = {imm[31:12], base[11:0]};
                enc.err  = (imm[11:0] != 12'd0);
            end
            F_LI: begin
                if (fits12) begin
                    enc.word = {imm[11:0], 5'd0, 3'b000, rd, OP_IMM};
                end else begin
                    enc.word = {hi20, rd, OP_LUI};
                    enc.two  = 1'b1;
                    enc.tail = {imm[11:0], rd, 3'b000, rd, OP_IMM};
                end
            end
            default: begin
                enc.word = base;
                enc.err  = 1'b1;
            end
        endcase
    end

    // Accept when empty, or when the final word is leaving this cycle.
    assign in_ready = !reset && ((state == S_EMPTY) || (state == S_ONE && out_ready));
    assign accept   = in_valid && in_ready;

    // Output stage: load a new encoding, advance lui->addi, or drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_EMPTY;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
            out_last  <= 1'b0;
            held      <= '0;
        end else if (accept) begin
            state     <= enc.two ? S_LUI : S_ONE;
            out_valid <= 1'b1;
            out_instr <= enc.word;
            out_err   <= enc.err;
            out_last  <= !enc.two;
            held      <= enc.tail;
        end else if (out_ready) begin
            unique case (state)
                S_ONE: begin
                    state     <= S_EMPTY;
                    out_valid <= 1'b0;
                end
                S_LUI: begin
                    state     <= S_ONE;
                    out_instr <= held;
                    out_err   <= 1'b0;
                    out_last  <= 1'b1;
                end
                default: begin
                    state     <= S_EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_encode.sv
// Bench for imm_encode: a word-level reference model feeds a scoreboard
// queue checked every cycle, plus directed vectors with literal results.
module tb_imm_encode;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  immsrc;
    logic [31:0] base;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic        out_last;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] w;
        logic        e;
        logic        l;
        logic [2:0]  src;
        logic [31:0] im;
    } exp_t;

    exp_t q[$];
    bit   prev_rst = 1'b1;

    imm_encode dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .immsrc    (immsrc),
        .base      (base),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: place fields arithmetically, judge range with integers.
    function automatic int model(input logic [2:0] src, input logic [31:0] b,
                                 input logic [31:0] im, output exp_t w0, output exp_t w1);
        int v;
        logic [31:0] rd, hi;
        v  = $signed(im);
        w0 = '{w: b, e: 1'b0, l: 1'b1, src: src, im: im};
        w1 = w0;
        case (src)
            3'd0: begin
                w0.w = (b & 32'h000FFFFF) | ((im & 32'hFFF) << 20);
                w0.e = (v < -2048) || (v > 2047);
            end
            3'd1: begin
                w0.w = (b & 32'h01FFF07F) | (((im >> 5) & 32'h7F) << 25) | ((im & 32'h1F) << 7);
                w0.e = (v < -2048) || (v > 2047);
            end
            3'd2: begin
                w0.w = (b & 32'h01FFF07F) | (((im >> 12) & 1) << 31) | (((im >> 11) & 1) << 7)
                     | (((im >> 5) & 32'h3F) << 25) | (((im >> 1) & 32'hF) << 8);
                w0.e = (v < -4096) || (v > 4094) || (im[0] == 1'b1);
            end
            3'd3: begin
                w0.w = (b & 32'hFFF) | (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                     | (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12);
                w0.e = (v < -1048576) || (v > 1048574) || (im[0] == 1'b1);
            end
            3'd4: begin
                w0.w = (b & 32'hFFF) | (im & 32'hFFFFF000);
                w0.e = (im & 32'hFFF) != 0;
            end
            3'd5: begin
                rd = (b >> 7) & 32'h1F;
                if (v >= -2048 && v <= 2047) begin
                    w0.w = ((im & 32'hFFF) << 20) | (rd << 7) | 32'h13;
                end else begin
                    hi   = (im + 32'h800) >> 12;
                    w0.w = (hi << 12) | (rd << 7) | 32'h37;
                    w0.l = 1'b0;
                    w1.w = ((im & 32'hFFF) << 20) | (rd << 15) | (rd << 7) | 32'h13;
                    return 2;
                end
            end
            default: w0.e = 1'b1;
        endcase
        return 1;
    endfunction

    // Datapath extractor, used to confirm encodings round-trip.
    function automatic logic [31:0] decode(input logic [31:0] i, input logic [2:0] src);
        case (src)
            3'd0:    return {{20{i[31]}}, i[31:20]};
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return {i[31:12], 12'd0};
        endcase
    endfunction

    // Compare process: check outputs against the scoreboard head each
    // cycle, then apply the handshakes that the next edge will perform.
    initial begin
        bit acc, fire, r;
        logic [2:0]  s_src;
        logic [31:0] s_base, s_imm;
        exp_t w0, w1;
        int n;
        forever begin
            @(negedge clk);
            if (reset) chk("in_ready_in_reset", in_ready, 0);
            if (prev_rst) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_instr", out_instr, 0);
                chk("rst_out_err",   out_err,   0);
                chk("rst_out_last",  out_last,  0);
            end else begin
                chk("sb_out_valid", out_valid, q.size() != 0);
                if (!reset)
                    chk("sb_in_ready", in_ready, (q.size() == 0) || (q.size() == 1 && out_ready));
                if (out_valid && q.size() != 0) begin
                    chk("sb_instr", out_instr, q[0].w);
                    chk("sb_err",   out_err,   q[0].e);
                    chk("sb_last",  out_last,  q[0].l);
                    if (!q[0].e && q[0].src <= 3'd4)
                        chk("roundtrip", decode(out_instr, q[0].src), q[0].im);
                end
            end
            acc = in_valid && in_ready;
            fire = out_valid && out_ready;
            r = reset;
            s_src = immsrc; s_base = base; s_imm = imm;
            @(posedge clk);
            prev_rst = r;
            if (r) q.delete();
            else begin
                if (fire && q.size() != 0) void'(q.pop_front());
                if (acc) begin
                    n = model(s_src, s_base, s_imm, w0, w1);
                    q.push_back(w0);
                    if (n == 2) q.push_back(w1);
                end
            end
        end
    end

    task automatic send(input logic [2:0] s, input logic [31:0] b, input logic [31:0] im);
        bit done;
        done = 0;
        @(posedge clk); #1;
        immsrc = s; base = b; imm = im; in_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                done = 1;
            end
        end
        if (!done) begin
            chk("send_timeout", 0, 1);
            in_valid = 1'b0;
        end
    endtask

    task automatic chk_lit(input string nm, input logic [31:0] w, input logic e, input logic l);
        @(negedge clk);
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_instr"}, out_instr, w);
        chk({nm, "_err"},   out_err,   e);
        chk({nm, "_last"},  out_last,  l);
    endtask

    function automatic logic [31:0] pick_imm();
        logic [31:0] tbl [14];
        tbl = '{32'd2047, -32'sd2048, 32'd2048, -32'sd2049, 32'd4094, 32'd4095, -32'sd4096,
                32'd1048574, -32'sd1048576, 32'h00100000, 32'h12345000, 32'h7FFFF800,
                32'h80000000, 32'hFFFFFFFF};
        case ($urandom_range(0, 5))
            0: return $urandom;
            1: return $urandom_range(0, 4095) - 2048;
            2: return tbl[$urandom_range(0, 13)];
            3: return $urandom & 32'hFFFFF000;
            4: return $urandom_range(0, 8191) - 4096;
            default: return ($urandom & 32'h001FFFFE) - 32'h00100000;
        endcase
    endfunction

    initial begin
        exp_t m0, m1;
        int n;
        bit accepted;

        // Requests during reset must be ignored.
        reset = 1'b1; in_valid = 1'b1; immsrc = 3'd0; base = 32'h93; imm = 32'd1; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", in_ready, 1);
        chk("no_accept_in_reset", out_valid, 0);

        // Pin the reference model with hand-computed words.
        n = model(3'd0, 32'h93, 32'hFFFFFFFF, m0, m1);
        chk("model_I", m0.w, 32'hFFF00093);
        n = model(3'd5, 32'h280, 32'h12345FFF, m0, m1);
        chk("model_LI_n", n, 2);
        chk("model_LI_lui", m0.w, 32'h123462B7);
        chk("model_LI_addi", m1.w, 32'hFFF28293);
        n = model(3'd2, 32'h63, 32'd3, m0, m1);
        chk("model_B_err", m0.e, 1);
        n = model(3'd4, 32'h37, 32'h12345000, m0, m1);
        chk("model_U", m0.w, 32'h12345037);

        // Directed formats.
        send(3'd0, 32'h93, 32'hFFFFFFFF);  chk_lit("I_neg1",  32'hFFF00093, 0, 1);
        send(3'd2, 32'h63, -32'sd4096);    chk_lit("B_min",   32'h80000063, 0, 1);
        send(3'd2, 32'h63, 32'd3);         chk_lit("B_odd",   32'h00000163, 1, 1);
        send(3'd3, 32'h6F, 32'h000FFFFE);  chk_lit("J_max",   32'h7FFFF06F, 0, 1);
        send(3'd3, 32'h6F, 32'h00100000);  chk_lit("J_over",  32'h8000006F, 1, 1);
        send(3'd4, 32'h37, 32'h12345000);  chk_lit("U",       32'h12345037, 0, 1);
        send(3'd4, 32'h37, 32'h00000001);  chk_lit("U_low",   32'h00000037, 1, 1);
        send(3'd6, 32'hDEADBEEF, 32'd0);   chk_lit("inval",   32'hDEADBEEF, 1, 1);
        send(3'd5, 32'h280, 32'h12345FFF); chk_lit("LI_lui",  32'h123462B7, 0, 0);
        chk("LI_lui_in_ready", in_ready, 0);
        chk_lit("LI_addi", 32'hFFF28293, 0, 1);
        send(3'd5, 32'h280, 32'd5);        chk_lit("LI_small", 32'h00500293, 0, 1);

        // Backpressure: held word stays put, pending request waits.
        @(posedge clk); #1 out_ready = 1'b0;
        send(3'd1, 32'h00002023, 32'h7FF);
        immsrc = 3'd0; base = 32'h13; imm = 32'd12; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_instr", out_instr, 32'h7E002FA3);
            chk("bp_ready", in_ready, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk); chk("bp_release", in_ready, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        chk_lit("bp_next", 32'h00C00013, 0, 1);

        // Back-to-back single-word requests, one per cycle.
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            immsrc = 3'd0; base = 32'h00000113; imm = k * 3 - 10; in_valid = 1'b1;
            @(negedge clk); chk("stream_ready", in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;

        // Reset while the lui word is presented drops the addi.
        @(posedge clk); #1 out_ready = 1'b0;
        send(3'd5, 32'h300, 32'h7FFFF800);
        @(negedge clk); chk("lui_pending_last", out_last, 0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk("no_addi_after_rst", out_valid, 0);
        end
        send(3'd0, 32'h93, 32'd5); chk_lit("after_rst", 32'h00500093, 0, 1);

        // Random traffic and backpressure; scoreboard checks every cycle.
        @(posedge clk); #1;
        accepted = 1'b1;
        in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || accepted) begin
                in_valid = ($urandom_range(0, 3) != 0);
                immsrc   = 3'($urandom_range(0, 7));
                base     = $urandom;
                imm      = pick_imm();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            accepted = in_valid && in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_encode.md
IMM_ENCODE -- requirements
Module: imm_encode

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  request valid.
REQ-004 in_ready  output  1  request accepted on a cycle with in_valid && in_ready.
REQ-005 immsrc  input  3  format: 000=I, 001=S, 010=B, 011=J, 100=U, 101=LI (load-immediate expansion), 110/111 invalid.
REQ-006 base  input  32  instruction template supplying opcode/funct/register fields; immediate bit positions are ignored.
REQ-007 imm  input  32  signed immediate, byte offset for B/J.
REQ-008 out_valid  output  1  encoded word valid.
REQ-009 out_ready  input  1  consumer accepts on out_valid && out_ready.
REQ-010 out_instr  output  32  encoded instruction word.
REQ-011 out_err  output  1  immediate not representable or immsrc invalid; qualified by out_valid.
REQ-012 out_last  output  1  final word for the current request.

Function
REQ-013 Encoding inverts the datapath immediate extractor: re-extracting out_instr with the same format SHALL return imm whenever out_err=0.
REQ-014 I: out_instr[31:20]=imm[11:0], rest from base; err if imm outside [-2048,2047].
REQ-015 S: [31:25]=imm[11:5], [11:7]=imm[4:0], rest from base; err if imm outside [-2048,2047].
REQ-016 B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]; err if imm outside [-4096,4094] or imm[0]=1.
REQ-017 J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]; err if imm outside [-1048576,1048574] or imm[0]=1.
REQ-018 U: [31:12]=imm[31:12]; err if imm[11:0]!=0.
REQ-019 Error cases SHALL still emit the truncated-field encoding with out_err=1, out_last=1.
REQ-020 Invalid immsrc SHALL emit base unchanged with out_err=1, out_last=1.
REQ-021 LI: rd=base[11:7]; if imm in [-2048,2047], emit one word addi rd,x0,imm (opcode 0010011, funct3 000); otherwise two words: lui rd,hi (opcode 0110111) with hi=(imm+0x800)[31:12], then addi rd,rd,imm[11:0]; out_err=0 always.
REQ-022 State machine: EMPTY (out_valid=0), ONE (final word presented, out_last=1), LUI (lui word presented, out_last=0, addi word held internally).
REQ-023 Transitions: EMPTY+accept -> ONE or LUI; ONE+output handshake+accept -> ONE or LUI; ONE+output handshake, no accept -> EMPTY; LUI+output handshake -> ONE with the held addi word; no handshake -> hold state.
REQ-024 in_ready = (state==EMPTY) || (state==ONE && out_ready); in_ready=0 in LUI.
REQ-025 Latency: word presented on out_* the cycle after acceptance; sustained throughput one single-word request per cycle.
REQ-026 While out_valid && !out_ready, out_instr/out_err/out_last SHALL be held stable.
REQ-027 All outputs except in_ready SHALL be registered; encoding is combinational from the input before the register.

Reset
REQ-028 During reset: state=EMPTY, out_valid=0, out_instr=0, out_err=0, out_last=0, in_ready=0; in_ready=1 the first cycle after reset deasserts.
REQ-029 Reset in LUI SHALL discard the held addi word; it is never emitted.
REQ-030 Request presented during reset SHALL NOT be accepted.

Verification
REQ-031 I: base=0x00000093, imm=-1 -> next cycle out_instr=0xFFF00093, out_err=0, out_last=1.
REQ-032 B: base=0x00000063, imm=-4096 -> 0x80000063, err=0; imm=3 -> out_err=1.
REQ-033 J: base=0x0000006F, imm=0x000FFFFE -> 0x7FFFF06F, err=0; imm=0x00100000 -> out_err=1.
REQ-034 LI: base=0x00000280, imm=0x12345FFF -> 0x123462B7 (last=0, in_ready=0) then 0xFFF28293 (last=1); imm=5 -> single 0x00500293.
REQ-035 Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_* stable, in_ready=0, no request lost or duplicated.
REQ-036 Reset asserted while in LUI -> next cycle out_valid=0; addi word never appears; next request encodes normally.
